// File: rtl/cmd_fetch_buffer_pkg.sv
// Shared types and width helpers for the command fetch buffer.
// The fetch FSM state type and the derived-width functions live here so the top and bench agree.
package gp_cmd_buf_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FETCH = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;

   function automatic int cmd_width(input int data_width, input int cmd_words);
      return data_width * cmd_words;
   endfunction

   function automatic int cmd_idx_width(input int trans_addr_width, input int cmd_words);
      return trans_addr_width - $clog2(cmd_words);
   endfunction

   // A single-word command still needs a 1-bit counter to keep the vector legal.
   function automatic int cnt_width(input int cmd_words);
      return (cmd_words > 1) ? $clog2(cmd_words) : 1;
   endfunction

endpackage

// File: rtl/cmd_fetch_buffer_mem.sv
// Word memory with one synchronous write port and one read port.
// A write and a read to the same word in the same cycle return the data being written.
module cmd_mem_1r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/cmd_fetch_buffer.sv
// Command buffer: AHB-written word memory, post-reset clear sweep, and a sequential
// fetch FSM that assembles CMD_WORDS-word commands for the engine.
module cmd_fetch_buffer
   import gp_cmd_buf_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int CMD_WORDS        = 2,
   parameter int BUFFER_DEPTH     = 256,
   parameter int TRANS_ADDR_WIDTH = 8,
   parameter int CMD_WIDTH        = cmd_width(DATA_WIDTH, CMD_WORDS),
   parameter int CMD_IDX_WIDTH    = cmd_idx_width(TRANS_ADDR_WIDTH, CMD_WORDS)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        cmd_rd_en,
   input  logic [CMD_IDX_WIDTH-1:0]    cmd_addr,
   output logic                        cmd_rd_valid,
   output logic [CMD_WIDTH-1:0]        cmd_out,
   output logic                        cmd_busy,
   input  logic                        cmd_en,
   input  logic [TRANS_ADDR_WIDTH-1:0] trans_addr,
   input  logic                        cmd_lock,
   input  logic                        slv_o_valid,
   input  logic [DATA_WIDTH-1:0]       slv_o_wr_data,
   input  logic                        slv_o_rd0_wr1,
   output logic                        slv_i_ready,
   output logic [DATA_WIDTH-1:0]       slv_i_rd_data,
   output logic                        slv_i_rd_valid,
   output logic                        slv_i_err
);

   localparam int CNT_W = cnt_width(CMD_WORDS);
   localparam int SHIFT = $clog2(CMD_WORDS);

   fetch_state_e                state_q, state_d;
   logic [TRANS_ADDR_WIDTH-1:0] sweep_q, sweep_d;
   logic [TRANS_ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CMD_WIDTH-1:0]        cmd_out_q, cmd_out_d;
   logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
   logic                        rd_valid_q, err_q;

   logic                        ahb_acc, ahb_rd, ahb_wr;
   logic                        mem_we;
   logic [TRANS_ADDR_WIDTH-1:0] mem_waddr, mem_raddr, fetch_addr;
   logic [DATA_WIDTH-1:0]       mem_wdata, mem_rdata;

   assign slv_i_ready = (state_q != ST_INIT);
   assign ahb_acc     = cmd_en && slv_o_valid && slv_i_ready;
   assign ahb_rd      = ahb_acc && !slv_o_rd0_wr1;
   assign ahb_wr      = ahb_acc && slv_o_rd0_wr1;
   assign fetch_addr  = base_q + TRANS_ADDR_WIDTH'(cnt_q);

   // The AHB read owns the single read port; the fetch simply retries next cycle.
   assign mem_raddr = ahb_rd ? trans_addr : fetch_addr;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = trans_addr;
      mem_wdata = slv_o_wr_data;
      if (!i_rst) begin
         if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
         end else if (ahb_wr && !cmd_lock) begin
            mem_we = 1'b1;
         end
      end
   end

   cmd_mem_1r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (TRANS_ADDR_WIDTH),
      .DEPTH      (BUFFER_DEPTH)
   ) u_mem (
      .clk_i   (i_clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      cmd_out_d = cmd_out_q;
      rd_data_d = ahb_rd ? mem_rdata : '0;
      case (state_q)
         ST_INIT: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == TRANS_ADDR_WIDTH'(BUFFER_DEPTH - 1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (cmd_rd_en) begin
               base_d  = TRANS_ADDR_WIDTH'(cmd_addr) << SHIFT;
               cnt_d   = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!ahb_rd) begin
               cmd_out_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
               if (cnt_q == CNT_W'(CMD_WORDS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_INIT;
         sweep_q    <= '0;
         base_q     <= '0;
         cnt_q      <= '0;
         cmd_out_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         cmd_out_q  <= cmd_out_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= ahb_rd;
         err_q      <= ahb_wr && cmd_lock;
      end
   end

   assign cmd_rd_valid   = (state_q == ST_DONE);
   assign cmd_busy       = (state_q != ST_IDLE);
   assign cmd_out        = cmd_out_q;
   assign slv_i_rd_data  = rd_data_q;
   assign slv_i_rd_valid = rd_valid_q;
   assign slv_i_err      = err_q;

endmodule
